alu_mc: RTL

Parametrised multi-cycle ALU for the multi-cycle MIPS datapath. It keeps the single-cycle integer operations of the existing ALU and adds shifts, iterative signed/unsigned multiply and iterative signed/unsigned divide. Operations are issued through a start/busy/done handshake. Results are registered: O carries the low word or quotient, and H carries the high word or remainder, as HI/LO sources for the EX stage.

---
 rtl/alu_mc.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the multi-cycle MIPS datapath.
// Single-cycle integer ops finish the cycle after start; multiply and divide
// run an iterative bit-serial engine (RUN, WIDTH cycles) followed by a sign
// fix-up cycle (FIX). O is the low word / quotient, H the high word / remainder.
//
// Handshake: an op is accepted on a rising clk edge where start=1 and busy=0.
// The accepting edge registers the result of a single-cycle op (done=1 in the
// following cycle) or loads the engine for a multi-cycle op (busy=1 until
// FIX ends). done is a one-cycle pulse; O/H/OV change only in the done cycle
// and hold otherwise. start while busy=1 is dropped.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       Func,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] H,
    output logic             OV
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Current FSM state; observable by name for checkers.
    state_t state;
    state_t state_next;

    // Engine working registers shared by multiply and divide.
    logic [WIDTH-1:0] acc;     // product high word / partial remainder
    logic [WIDTH-1:0] lo;      // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0] opb;     // multiplicand / divisor magnitude
    logic [WIDTH-1:0] a_save;  // original A, returned as H on divide by zero
    logic [SHW-1:0]   count;
    logic             is_div;
    logic             neg_q;   // negate product / quotient in FIX
    logic             neg_r;   // negate remainder in FIX (sign of A)
    logic             dbz;     // divide by zero

    logic issue;
    logic is_multi;
    logic last_step;

    assign issue     = start && (state == IDLE);
    assign is_multi  = Func[3] & Func[2];
    assign last_step = &count;
    assign busy      = (state != IDLE);

    // Operand conditioning for multi-cycle ops: odd codes (MUL, DIV) are signed.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_neg = Func[0] & A[WIDTH-1];
    assign b_neg = Func[0] & B[WIDTH-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    // Single-cycle result and overflow.
    logic [WIDTH-1:0] alu_o;
    logic             alu_ov;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;

    assign sum = A + B;
    assign dif = A - B;

    // Combinational single-cycle ALU; multi-cycle codes give zero here.
    always_comb begin
        alu_o  = '0;
        alu_ov = 1'b0;
        case (Func)
            4'd0: begin
                alu_o  = sum;
                alu_ov = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            4'd1: begin
                alu_o  = dif;
                alu_ov = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
            end
            4'd2:    alu_o = A & B;
            4'd3:    alu_o = A | B;
            4'd4:    alu_o = ~(A | B);
            4'd5:    alu_o = ~(A & B);
            4'd6:    alu_o = {{(WIDTH-1){1'b0}}, (A < B)};
            4'd7:    alu_o = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'd8:    alu_o = A ^ B;
            4'd9:    alu_o = A << B[SHW-1:0];
            4'd10:   alu_o = A >> B[SHW-1:0];
            4'd11:   alu_o = $signed(A) >>> B[SHW-1:0];
            default: alu_o = '0;
        endcase
    end

    // One engine step: shift-add for multiply, restoring subtract for divide.
    logic [WIDTH:0]   madd;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] sub_res;

    assign madd    = {1'b0, acc} + (lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign shifted = {acc, lo[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, opb});
    // When ge holds the true difference is below the divisor, so WIDTH bits suffice.
    assign sub_res = shifted[WIDTH-1:0] - opb;

    // Sign fix-up applied in FIX.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_o;
    logic [WIDTH-1:0]   fix_h;
    logic               fix_ov;

    assign prod     = {acc, lo};
    assign prod_fix = neg_q ? -prod : prod;

    // Final result selection for multiply / divide / divide-by-zero.
    always_comb begin
        fix_o  = prod_fix[WIDTH-1:0];
        fix_h  = prod_fix[2*WIDTH-1:WIDTH];
        fix_ov = 1'b0;
        if (is_div) begin
            if (dbz) begin
                fix_o  = '1;
                fix_h  = a_save;
                fix_ov = 1'b1;
            end else begin
                fix_o = neg_q ? -lo : lo;
                fix_h = neg_r ? -acc : acc;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN (WIDTH steps) -> FIX -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue && is_multi) state_next = RUN;
            RUN:     if (last_step) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand load, iterative steps, and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            lo     <= '0;
            opb    <= '0;
            a_save <= '0;
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz    <= 1'b0;
            done   <= 1'b0;
            O      <= '0;
            H      <= '0;
            OV     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        if (is_multi) begin
                            acc    <= '0;
                            lo     <= a_mag;
                            opb    <= b_mag;
                            a_save <= A;
                            count  <= '0;
                            is_div <= Func[1];
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            dbz    <= Func[1] && (B == '0);
                        end else begin
                            O    <= alu_o;
                            H    <= '0;
                            OV   <= alu_ov;
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (is_div) begin
                        if (ge) begin
                            acc <= sub_res;
                            lo  <= {lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= shifted[WIDTH-1:0];
                            lo  <= {lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= madd[WIDTH:1];
                        lo  <= {madd[0], lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    O    <= fix_o;
                    H    <= fix_h;
                    OV   <= fix_ov;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
